// File: rtl/coffee_order_fsm_if.sv
// Coffee sequencer pulse/display bundle: front-panel pulses in, display/dispense outputs back.
// master = stimulus/front-panel side, slave = sequencer side.
interface coffee_order_if;
    logic        coin_pulse;
    logic        coffee_btn;
    logic        return_btn;
    logic        brew_done;
    logic [13:0] fnd_data;
    logic        anim_en;
    logic        coin_reject;
    logic        change_pulse;

    modport master (
        output coin_pulse, coffee_btn, return_btn, brew_done,
        input  fnd_data, anim_en, coin_reject, change_pulse
    );

    modport slave (
        input  coin_pulse, coffee_btn, return_btn, brew_done,
        output fnd_data, anim_en, coin_reject, change_pulse
    );
endinterface

// File: rtl/coffee_order_fsm.sv
// Coffee-machine sequencer: coin credit, cup sale, change return, display value/animation.
// Optional BREW watchdog refund enabled by defining BREW_WATCHDOG_EN.
module coffee_order_fsm #(
    parameter int unsigned COIN_VAL            = 100,
    parameter int unsigned PRICE               = 300,
    parameter int unsigned MAX_BALANCE         = 9900,
    parameter int unsigned CHANGE_HOLD_CYCLES  = 200_000_000,
    parameter int unsigned BREW_TIMEOUT_CYCLES = 700_000_000
) (
    input logic           clk,
    input logic           reset,
    coffee_order_if.slave bus
);

    localparam int unsigned BAL_W  = 14;
    localparam int unsigned HOLD_W = $clog2(CHANGE_HOLD_CYCLES + 1);
`ifdef BREW_WATCHDOG_EN
    localparam int unsigned WD_W   = $clog2(BREW_TIMEOUT_CYCLES + 1);
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        BREW   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic [BAL_W-1:0]   change_q, change_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
`ifdef BREW_WATCHDOG_EN
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [BAL_W:0]     refund_sum;
`endif
    logic [BAL_W:0]     coin_sum;
    logic               coin_ok;

    logic [BAL_W-1:0]   fnd_q, fnd_d;
    logic               anim_q, anim_d;
    logic               reject_q, reject_d;
    logic               chg_pulse_q, chg_pulse_d;

    // State, datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            balance_q   <= '0;
            change_q    <= '0;
            hold_q      <= '0;
`ifdef BREW_WATCHDOG_EN
            wd_q        <= '0;
`endif
            fnd_q       <= '0;
            anim_q      <= 1'b0;
            reject_q    <= 1'b0;
            chg_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            balance_q   <= balance_d;
            change_q    <= change_d;
            hold_q      <= hold_d;
`ifdef BREW_WATCHDOG_EN
            wd_q        <= wd_d;
`endif
            fnd_q       <= fnd_d;
            anim_q      <= anim_d;
            reject_q    <= reject_d;
            chg_pulse_q <= chg_pulse_d;
        end
    end

    // Next state and credit bookkeeping; button priority is return > coffee > coin
    always_comb begin
        state_d   = state_q;
        balance_d = balance_q;
        change_d  = change_q;
        hold_d    = hold_q;
        coin_ok   = 1'b0;
        coin_sum  = (BAL_W+1)'(balance_q) + (BAL_W+1)'(COIN_VAL);
`ifdef BREW_WATCHDOG_EN
        wd_d       = wd_q;
        refund_sum = (BAL_W+1)'(balance_q) + (BAL_W+1)'(PRICE);
`endif
        case (state_q)
            IDLE, CREDIT: begin
                if (bus.return_btn) begin
                    if (state_q == CREDIT) begin
                        change_d  = balance_q;
                        balance_d = '0;
                        hold_d    = '0;
                        state_d   = CHANGE;
                    end
                end else if (bus.coffee_btn) begin
                    if (state_q == CREDIT && balance_q >= BAL_W'(PRICE)) begin
                        balance_d = balance_q - BAL_W'(PRICE);
                        state_d   = BREW;
`ifdef BREW_WATCHDOG_EN
                        wd_d      = '0;
`endif
                    end
                end else if (bus.coin_pulse) begin
                    if (coin_sum <= (BAL_W+1)'(MAX_BALANCE)) begin
                        coin_ok   = 1'b1;
                        balance_d = BAL_W'(coin_sum);
                        state_d   = CREDIT;
                    end
                end
            end
            BREW: begin
                if (bus.brew_done) begin
                    state_d = (balance_q != '0) ? CREDIT : IDLE;
`ifdef BREW_WATCHDOG_EN
                end else if (wd_q == WD_W'(BREW_TIMEOUT_CYCLES - 1)) begin
                    balance_d = (refund_sum > (BAL_W+1)'(MAX_BALANCE)) ?
                                BAL_W'(MAX_BALANCE) : BAL_W'(refund_sum);
                    state_d   = CREDIT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
`endif
                end
            end
            CHANGE: begin
                if (hold_q == HOLD_W'(CHANGE_HOLD_CYCLES - 1)) begin
                    change_d = '0;
                    state_d  = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        fnd_d       = (state_d == CHANGE) ? change_d : balance_d;
        anim_d      = (state_d == BREW);
        reject_d    = bus.coin_pulse && !coin_ok;
        chg_pulse_d = (state_q != CHANGE) && (state_d == CHANGE);
    end

    assign bus.fnd_data     = fnd_q;
    assign bus.anim_en      = anim_q;
    assign bus.coin_reject  = reject_q;
    assign bus.change_pulse = chg_pulse_q;

endmodule

// File: tb/tb_coffee_order_fsm.sv
// Directed bench for coffee_order_fsm: credit/price model checked every cycle plus literal pins.
module tb_coffee_order_fsm;

    localparam int unsigned COIN  = 100;
    localparam int unsigned PRICE = 300;
    localparam int unsigned MAXB  = 9900;
    localparam int unsigned HOLD  = 10;
    localparam int unsigned TMO   = 20;
`ifdef BREW_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic clk;
    logic reset;
    coffee_order_if bus ();

    coffee_order_fsm #(
        .COIN_VAL(COIN), .PRICE(PRICE), .MAX_BALANCE(MAXB),
        .CHANGE_HOLD_CYCLES(HOLD), .BREW_TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Model: credit in cents, change-display countdown, brewing flag
    int m_bal, m_show, change_left, brew_age;
    bit brewing;
    int e_fnd;
    bit e_anim, e_rej, e_chg;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_bal = 0; m_show = 0; change_left = 0; brew_age = 0; brewing = 0;
        e_fnd = 0; e_anim = 0; e_rej = 0; e_chg = 0;
    endtask

    task automatic m_step(input bit coin, input bit coffee, input bit ret, input bit done);
        e_rej = 0;
        e_chg = 0;
        if (change_left > 0) begin
            e_rej = coin;
            change_left--;
        end else if (brewing) begin
            e_rej = coin;
            if (done) brewing = 0;
            else begin
                brew_age++;
                if (WD && brew_age == TMO) begin
                    m_bal   = (m_bal + PRICE > MAXB) ? MAXB : m_bal + PRICE;
                    brewing = 0;
                end
            end
        end else if (ret) begin
            e_rej = coin;
            if (m_bal > 0) begin
                m_show = m_bal; m_bal = 0; change_left = HOLD; e_chg = 1;
            end
        end else if (coffee) begin
            e_rej = coin;
            if (m_bal >= PRICE) begin
                m_bal -= PRICE; brewing = 1; brew_age = 0;
            end
        end else if (coin) begin
            if (m_bal + COIN <= MAXB) m_bal += COIN;
            else e_rej = 1;
        end
        e_anim = brewing;
        e_fnd  = (change_left > 0) ? m_show : m_bal;
    endtask

    // One clock with the given pulses; returns at posedge+1 with inputs cleared
    task automatic cyc(input bit coin, input bit coffee, input bit ret, input bit done);
        bus.coin_pulse = coin;
        bus.coffee_btn = coffee;
        bus.return_btn = ret;
        bus.brew_done  = done;
        @(posedge clk);
        m_step(coin, coffee, ret, done);
        #1;
        bus.coin_pulse = 1'b0;
        bus.coffee_btn = 1'b0;
        bus.return_btn = 1'b0;
        bus.brew_done  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    task automatic coins(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        m_reset();
        #1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("fnd_data",     32'(bus.fnd_data),     32'(e_fnd));
        chk("anim_en",      32'(bus.anim_en),      32'(e_anim));
        chk("coin_reject",  32'(bus.coin_reject),  32'(e_rej));
        chk("change_pulse", 32'(bus.change_pulse), 32'(e_chg));
    end

    initial begin
        bus.coin_pulse = 1'b0;
        bus.coffee_btn = 1'b0;
        bus.return_btn = 1'b0;
        bus.brew_done  = 1'b0;
        m_reset();
        reset = 1'b1;
        #12;
        chk("reset_fnd",  32'(bus.fnd_data), 32'd0);
        chk("reset_anim", 32'(bus.anim_en),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Four coins then a cup
        cyc(1, 0, 0, 0); chk("coin1", 32'(bus.fnd_data), 32'd100);
        cyc(1, 0, 0, 0); chk("coin2", 32'(bus.fnd_data), 32'd200);
        cyc(1, 0, 0, 0); chk("coin3", 32'(bus.fnd_data), 32'd300);
        cyc(1, 0, 0, 0); chk("coin4", 32'(bus.fnd_data), 32'd400);
        cyc(0, 1, 0, 0);
        chk("sell_fnd",  32'(bus.fnd_data), 32'd100);
        chk("sell_anim", 32'(bus.anim_en),  32'd1);
        idle(5);
        cyc(0, 0, 0, 1);
        chk("done_anim", 32'(bus.anim_en),  32'd0);
        chk("done_fnd",  32'(bus.fnd_data), 32'd100);
        cyc(0, 0, 1, 0);
        idle(HOLD);
        chk("flush_fnd", 32'(bus.fnd_data), 32'd0);

        // Insufficient credit, then refund with hold timing
        coins(2);
        cyc(0, 1, 0, 0);
        chk("short_fnd",  32'(bus.fnd_data), 32'd200);
        chk("short_anim", 32'(bus.anim_en),  32'd0);
        cyc(0, 0, 1, 0);
        chk("ret_pulse", 32'(bus.change_pulse), 32'd1);
        chk("ret_fnd",   32'(bus.fnd_data),     32'd200);
        cyc(0, 0, 0, 0);
        chk("ret_pulse_once", 32'(bus.change_pulse), 32'd0);
        idle(HOLD - 2);
        chk("hold_last", 32'(bus.fnd_data), 32'd200);
        cyc(0, 0, 0, 0);
        chk("hold_end", 32'(bus.fnd_data), 32'd0);

        // Ceiling, then coin + return in the same cycle
        coins(99);
        chk("max_fnd", 32'(bus.fnd_data), 32'd9900);
        cyc(1, 0, 0, 0);
        chk("max_rej", 32'(bus.coin_reject), 32'd1);
        chk("max_keep", 32'(bus.fnd_data),   32'd9900);
        cyc(1, 0, 1, 0);
        chk("race_rej", 32'(bus.coin_reject),  32'd1);
        chk("race_chg", 32'(bus.change_pulse), 32'd1);
        chk("race_fnd", 32'(bus.fnd_data),     32'd9900);
        idle(HOLD);

        // Coins during BREW and CHANGE bounce
        coins(3);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("brew_rej", 32'(bus.coin_reject), 32'd1);
        chk("brew_bal", 32'(bus.fnd_data),    32'd0);
        cyc(0, 1, 1, 0);
        chk("brew_btn_ign", 32'(bus.anim_en), 32'd1);
        cyc(0, 0, 0, 1);
        coins(1);
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        chk("chg_rej", 32'(bus.coin_reject), 32'd1);
        chk("chg_fnd", 32'(bus.fnd_data),    32'd100);
        idle(HOLD);
        cyc(0, 0, 0, 1);
        chk("stray_done", 32'(bus.fnd_data), 32'd0);

        // Brew with no brew_done
        coins(3);
        cyc(0, 1, 0, 0);
`ifdef BREW_WATCHDOG_EN
        idle(TMO - 1);
        chk("wd_pre_anim", 32'(bus.anim_en), 32'd1);
        cyc(0, 0, 0, 0);
        chk("wd_anim", 32'(bus.anim_en),  32'd0);
        chk("wd_fnd",  32'(bus.fnd_data), 32'd300);
        idle(5);
`else
        idle(100);
        chk("nowd_anim", 32'(bus.anim_en), 32'd1);
`endif
        do_reset();

        // Asynchronous reset mid-BREW with leftover credit
        coins(5);
        cyc(0, 1, 0, 0);
        chk("pre_rst_fnd", 32'(bus.fnd_data), 32'd200);
        idle(2);
        #1;
        reset = 1'b1;
        m_reset();
        #1;
        chk("arst_fnd",  32'(bus.fnd_data), 32'd0);
        chk("arst_anim", 32'(bus.anim_en),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(3);
        cyc(1, 0, 0, 0);
        chk("post_rst_coin", 32'(bus.fnd_data), 32'd100);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
